traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

- Passive checker on the four-way light bus (`east`, `south`, `west`, `north`) driven by the traffic light controller.
- Decodes each sampled light pattern into a phase, locks onto the 8-phase rotation and checks sequence order and dwell lengths.
- Reports the current phase and any fault with a sticky cause code.
- Sits beside the controller in the intersection subsystem and is the receiving end of its light outputs.

## Interface
- `GREEN_CYCLES`, 8: required dwell of a green phase, in clocks.
- `YELLOW_CYCLES`, 5: required dwell of a yellow phase, in clocks.
- `DW`, 4: dwell counter width. Legal: `GREEN_CYCLES` and `YELLOW_CYCLES` in 1..2^DW-2.
- `clk`  in  1  sole clock. All logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `east`, `south`, `west`, `north`  in  3 each  light codes: 1 = GREEN, 2 = YELLOW, 3 = RED. Any other value is illegal.
- `clr_fault`  in  1  single-cycle pulse that clears a latched fault.
- `locked`  out  1  monitor is tracking the rotation.
- `phase`  out  3  last decoded legal phase, 0..7.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  2  first fault cause: 0 ILLEGAL, 1 SEQUENCE, 2 DWELL_SHORT, 3 DWELL_LONG.
- `rotations`  out  8  completed full rotations.

## Operation
- **Phase decode.** The tuple (E, S, W, N) maps to a phase; any other tuple is ILLEGAL.
  - 0 = (G,R,R,R)
  - 1 = (Y,Y,R,R)
  - 2 = (R,G,R,R)
  - 3 = (R,Y,Y,R)
  - 4 = (R,R,G,R)
  - 5 = (R,R,Y,Y)
  - 6 = (R,R,R,G)
  - 7 = (Y,R,R,Y)
- Even phases are green and expect `GREEN_CYCLES`. Odd phases are yellow and expect `YELLOW_CYCLES`.
- **Dwell counter.** Counts consecutive samples of the same phase. It loads 1 on a phase change and saturates at 2^DW-1.
- **FSM states:** SYNC, LOCKED, FAULT. Reset enters SYNC.
- **SYNC**
  - A change to phase (p+1) mod 8 moves to LOCKED with dwell = 1.
  - Any other legal change stays in SYNC with no fault.
  - The dwell of the partial first phase is never checked.
- **LOCKED.** Each sample is checked in this priority order:
  1. ILLEGAL pattern → FAULT, code 0.
  2. Change to a phase other than (p+1) mod 8 → FAULT, code 1.
  3. Change after a dwell below the expected count → FAULT, code 2.
  4. Same phase sampled when dwell already equals the expected count → FAULT, code 3.
- **ILLEGAL in SYNC** → FAULT, code 0.
- **FAULT**
  - `fault` = 1 and `locked` = 0.
  - `fault_code` holds the first cause; later faults do not overwrite it.
  - `phase` keeps tracking legal patterns.
  - `clr_fault` moves to SYNC and clears `fault` and `fault_code`.
- **Simultaneous events**
  - If `clr_fault` and a new fault are evaluated in the same cycle, the new fault wins: state FAULT with the new code.
  - `clr_fault` outside FAULT is ignored.
- **Rotations.** Increments when LOCKED and phase goes 7→0. Wraps 255→0. Unaffected by faults; cleared only by reset.

## Timing
- Light inputs are registered once. All outputs are registered.
- A light change presented before edge N appears on outputs after edge N+1 (2-clock latency).
- Reset values: `locked` 0, `phase` 0, `fault` 0, `fault_code` 0, `rotations` 0, FSM SYNC, dwell 0, input registers all-RED (3).
- Asserting `rst` mid-rotation clears everything immediately, without waiting for `clk`. After release the monitor re-syncs at the next legal successor transition.
- With the controller and monitor released from reset together, the controller holds phase 0 for 8 clocks. The monitor then sees the 0→1 change and `locked` rises.
- One nominal rotation is 4·(8+5) = 52 clocks.

## Configuration
- Macro: `TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN`.
- **Defined:** `rotations` counts as above.
- **Undefined:** the counter is not built and `rotations` is tied to 0. Port list unchanged.

## Test plan
- Bench model of the controller, reset released at cycle 0 → `locked` = 1 at cycle 10; `phase` steps 0,1,2,…,7,0; `fault` stays 0 over 500 cycles.
- Nominal run for 3·52 clocks after lock → `rotations` = 3 (or 0 with the macro undefined).
- When locked, force (G,G,R,R) for one cycle → `fault` = 1, `fault_code` = 0, `locked` = 0 two clocks later. A later dwell error leaves code 0.
- Cut green phase 2 to 7 clocks → `fault_code` = 2 at the 2→3 change. Stretch yellow phase 3 to 6 clocks → `fault_code` = 3 at the sixth sample.
- Skip phase 1 (0→2) → `fault_code` = 1. Pulse `clr_fault` → SYNC, then `locked` again after the next legal transition. `clr_fault` coincident with an ILLEGAL sample → `fault` stays 1 with `fault_code` = 0.
- Assert `rst` mid-phase 5 → all outputs at reset values before the next edge. After release, monitor re-locks without `fault`.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the four-way light bus; decodes phases, locks onto the rotation, flags order/dwell faults.
// Optional rotation counter is built when TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN is defined; otherwise rotations reads 0.
//
// state     | meaning
// ST_SYNC   | waiting for a legal successor transition to lock onto
// ST_LOCKED | tracking the rotation, checking order and dwell on every sample
// ST_FAULT  | fault latched, first cause held until clr_fault
module traffic_light_monitor #(
   parameter int GREEN_CYCLES  = 8,
   parameter int YELLOW_CYCLES = 5,
   parameter int DW            = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] east,
   input  logic [2:0] south,
   input  logic [2:0] west,
   input  logic [2:0] north,
   input  logic       clr_fault,
   output logic       locked,
   output logic [2:0] phase,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [7:0] rotations
);

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   localparam logic [2:0]    LG = 3'd1;
   localparam logic [2:0]    LY = 3'd2;
   localparam logic [2:0]    LR = 3'd3;
   localparam logic [1:0]    C_ILLEGAL = 2'd0;
   localparam logic [1:0]    C_SEQ     = 2'd1;
   localparam logic [1:0]    C_SHORT   = 2'd2;
   localparam logic [1:0]    C_LONG    = 2'd3;
   localparam logic [DW-1:0] DWELL_ONE = DW'(1);
   localparam logic [DW-1:0] DWELL_MAX = {DW{1'b1}};
   localparam logic [DW-1:0] G_EXP     = DW'(GREEN_CYCLES);
   localparam logic [DW-1:0] Y_EXP     = DW'(YELLOW_CYCLES);

   logic [11:0]   lights_d, lights_q;
   logic          in_vld_d, in_vld_q;
   state_t        state_d, state_q;
   logic [2:0]    phase_d, phase_q;
   logic [DW-1:0] dwell_d, dwell_q;
   logic          locked_d, locked_q;
   logic          fault_d, fault_q;
   logic [1:0]    fault_code_d, fault_code_q;

   logic          dec_vld;
   logic [2:0]    dec_ph;
   logic          changed;
   logic [2:0]    succ;
   logic [DW-1:0] exp_dwell;
`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
   logic          rot_inc;
   logic [7:0]    rot_d, rot_q;
`endif

   always_comb begin
      lights_d = {east, south, west, north};
      in_vld_d = 1'b1;
   end

   always_comb begin
      dec_vld = 1'b1;
      dec_ph  = 3'd0;
      case (lights_q)
         {LG, LR, LR, LR}: dec_ph = 3'd0;
         {LY, LY, LR, LR}: dec_ph = 3'd1;
         {LR, LG, LR, LR}: dec_ph = 3'd2;
         {LR, LY, LY, LR}: dec_ph = 3'd3;
         {LR, LR, LG, LR}: dec_ph = 3'd4;
         {LR, LR, LY, LY}: dec_ph = 3'd5;
         {LR, LR, LR, LG}: dec_ph = 3'd6;
         {LY, LR, LR, LY}: dec_ph = 3'd7;
         default:          dec_vld = 1'b0;
      endcase
   end

   assign changed   = (dec_ph != phase_q);
   assign succ      = phase_q + 3'd1;
   assign exp_dwell = phase_q[0] ? Y_EXP : G_EXP;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      dwell_d      = dwell_q;
      fault_code_d = fault_code_q;
`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
      rot_inc      = 1'b0;
`endif
      // The reset value of the input registers is not a real sample; skip it.
      if (in_vld_q) begin
         if (dec_vld) begin
            phase_d = dec_ph;
            if (changed)
               dwell_d = DWELL_ONE;
            else if (dwell_q != DWELL_MAX)
               dwell_d = dwell_q + DWELL_ONE;
         end
         case (state_q)
            ST_SYNC: begin
               if (!dec_vld) begin
                  state_d      = ST_FAULT;
                  fault_code_d = C_ILLEGAL;
               end else if (changed && (dec_ph == succ)) begin
                  state_d = ST_LOCKED;
               end
            end
            ST_LOCKED: begin
`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
               rot_inc = dec_vld && changed && (phase_q == 3'd7) && (dec_ph == 3'd0);
`endif
               if (!dec_vld) begin
                  state_d      = ST_FAULT;
                  fault_code_d = C_ILLEGAL;
               end else if (changed && (dec_ph != succ)) begin
                  state_d      = ST_FAULT;
                  fault_code_d = C_SEQ;
               end else if (changed && (dwell_q < exp_dwell)) begin
                  state_d      = ST_FAULT;
                  fault_code_d = C_SHORT;
               end else if (!changed && (dwell_q == exp_dwell)) begin
                  state_d      = ST_FAULT;
                  fault_code_d = C_LONG;
               end
            end
            ST_FAULT: begin
               // A fresh illegal sample beats a coincident clear and re-latches its own code.
               if (!dec_vld) begin
                  if (clr_fault)
                     fault_code_d = C_ILLEGAL;
               end else if (clr_fault) begin
                  state_d      = ST_SYNC;
                  fault_code_d = C_ILLEGAL;
               end
            end
            default: state_d = ST_SYNC;
         endcase
      end
      locked_d = (state_d == ST_LOCKED);
      fault_d  = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lights_q     <= {LR, LR, LR, LR};
         in_vld_q     <= 1'b0;
         state_q      <= ST_SYNC;
         phase_q      <= 3'd0;
         dwell_q      <= '0;
         locked_q     <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 2'd0;
      end else begin
         lights_q     <= lights_d;
         in_vld_q     <= in_vld_d;
         state_q      <= state_d;
         phase_q      <= phase_d;
         dwell_q      <= dwell_d;
         locked_q     <= locked_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
   always_comb begin
      rot_d = rot_q;
      if (rot_inc)
         rot_d = rot_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rot_q <= 8'd0;
      else
         rot_q <= rot_d;
   end

   assign rotations = rot_q;
`else
   assign rotations = 8'd0;
`endif

   assign locked     = locked_q;
   assign phase      = phase_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: controller model drives the bus, a behavioural monitor model predicts outputs.
module tb_traffic_light_monitor;

   localparam int G = 8;
   localparam int Y = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr_fault;
   logic [2:0] east, south, west, north;
   logic       locked, fault;
   logic [2:0] phase;
   logic [1:0] fault_code;
   logic [7:0] rotations;

   traffic_light_monitor #(.GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .DW(4)) dut (
      .clk(clk), .rst(rst),
      .east(east), .south(south), .west(west), .north(north),
      .clr_fault(clr_fault),
      .locked(locked), .phase(phase), .fault(fault),
      .fault_code(fault_code), .rotations(rotations)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [11:0] cur_pat = 12'hDB6;
   logic        cur_clr = 1'b0;
   logic [11:0] prev_pat;
   bit          prev_vld = 1'b0;
   bit          inj_pend = 1'b0;
   logic [11:0] inj_pat;
   int          ctl_phase, ctl_left, tcount;
   // model: mode 0 = syncing, 1 = tracking, 2 = faulted
   int          m_mode, m_phase, m_dwell, m_code, m_rot;

   function automatic logic [11:0] pat(input int ph);
      case (ph)
         0: return {3'd1, 3'd3, 3'd3, 3'd3};
         1: return {3'd2, 3'd2, 3'd3, 3'd3};
         2: return {3'd3, 3'd1, 3'd3, 3'd3};
         3: return {3'd3, 3'd2, 3'd2, 3'd3};
         4: return {3'd3, 3'd3, 3'd1, 3'd3};
         5: return {3'd3, 3'd3, 3'd2, 3'd2};
         6: return {3'd3, 3'd3, 3'd3, 3'd1};
         default: return {3'd2, 3'd3, 3'd3, 3'd2};
      endcase
   endfunction

   function automatic int decode(input logic [11:0] x);
      for (int i = 0; i < 8; i++)
         if (pat(i) === x) return i;
      return -1;
   endfunction

   function automatic int nominal(input int ph);
      return (ph % 2 == 0) ? G : Y;
   endfunction

   function automatic logic [11:0] rand_illegal();
      logic [11:0] x;
      do x = 12'($urandom); while (decode(x) >= 0);
      return x;
   endfunction

   function automatic logic [14:0] exp_out();
      logic [7:0] r;
`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
      r = 8'(m_rot % 256);
`else
      r = 8'd0;
`endif
      return {(m_mode == 1), 3'(m_phase), (m_mode == 2), 2'(m_code), r};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_phase = 0; m_dwell = 0; m_code = 0; m_rot = 0;
      prev_vld = 1'b0;
   endtask

   task automatic model_step(input logic [11:0] x, input logic c);
      int ph, expd;
      bit chg;
      ph = decode(x);
      if (ph < 0) begin
         if (m_mode != 2) begin m_mode = 2; m_code = 0; end
         else if (c) m_code = 0;
         return;
      end
      chg  = (ph != m_phase);
      expd = nominal(m_phase);
      if (m_mode == 0) begin
         if (chg && ph == (m_phase + 1) % 8) m_mode = 1;
      end else if (m_mode == 1) begin
         if (chg && m_phase == 7 && ph == 0) m_rot++;
         if (chg && ph != (m_phase + 1) % 8) begin m_mode = 2; m_code = 1; end
         else if (chg && m_dwell < expd)     begin m_mode = 2; m_code = 2; end
         else if (!chg && m_dwell == expd)   begin m_mode = 2; m_code = 3; end
      end else if (c) begin
         m_mode = 0; m_code = 0;
      end
      m_dwell = chg ? 1 : ((m_dwell < 15) ? m_dwell + 1 : 15);
      m_phase = ph;
   endtask

   task automatic tick();
      {east, south, west, north} = cur_pat;
      clr_fault = cur_clr;
      @(posedge clk);
      if (prev_vld) model_step(prev_pat, cur_clr);
      prev_pat = cur_pat;
      prev_vld = 1'b1;
      tcount++;
      #1;
      cur_clr = 1'b0;
   endtask

   task automatic ctl_step();
      cur_pat = inj_pend ? inj_pat : pat(ctl_phase);
      inj_pend = 1'b0;
      tick();
      ctl_left--;
      if (ctl_left <= 0) begin
         ctl_phase = (ctl_phase + 1) % 8;
         ctl_left  = nominal(ctl_phase);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; clr_fault = 1'b0;
      {east, south, west, north} = cur_pat;
      #1 rst = 1'b0;
      #2;
      vectors++;
      if ({locked, phase, fault, fault_code, rotations} !== 15'd0) begin
         miscompares++;
         $display("FAIL reset_state got %h want 0", {locked, phase, fault, fault_code, rotations});
      end
   endtask

   task automatic test_lock();
      logic [7:0] rot3;
`ifdef TRAFFIC_LIGHT_MONITOR_ROTATION_COUNT_EN
      rot3 = 8'd3;
`else
      rot3 = 8'd0;
`endif
      model_reset();
      ctl_phase = 0; ctl_left = G; tcount = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 500; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL nominal_run t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
         if (tcount == 9 || tcount == 10) begin
            vectors++;
            if (locked !== (tcount == 10)) begin
               miscompares++;
               $display("FAIL lock_time t=%0d got %b want %b", tcount, locked, (tcount == 10));
            end
         end
         if (tcount == 166) begin
            vectors++;
            if (rotations !== rot3) begin
               miscompares++;
               $display("FAIL rotations_3 got %0d want %0d", rotations, rot3);
            end
         end
      end
      vectors++;
      if (fault !== 1'b0) begin
         miscompares++;
         $display("FAIL no_fault_500 got %b want 0", fault);
      end
   endtask

   task automatic test_illegal();
      int wait_n, k;
      wait_n = $urandom_range(5, 40);
      for (int i = 0; i < wait_n; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL illegal_pre t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      inj_pend = 1'b1; inj_pat = {3'd1, 3'd1, 3'd3, 3'd3};
      ctl_step();
      ctl_step();
      vectors++;
      if ({locked, fault, fault_code} !== 4'b0100) begin
         miscompares++;
         $display("FAIL illegal_fault got lk=%b f=%b c=%0d want lk=0 f=1 c=0", locked, fault, fault_code);
      end
      k = 0;
      while (!(ctl_phase % 2 == 0 && ctl_left == G) && k < 20) begin ctl_step(); k++; end
      ctl_left = G - 3;
      for (int i = 0; i < 20; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL illegal_hold t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if (fault_code !== 2'd0) begin
         miscompares++;
         $display("FAIL first_code_kept got %0d want 0", fault_code);
      end
      cur_clr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL illegal_clr t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if (locked !== 1'b1) begin
         miscompares++;
         $display("FAIL relock_after_clr got %b want 1", locked);
      end
   endtask

   task automatic test_dwell();
      int k;
      k = 0;
      while (!(ctl_phase == 2 && ctl_left == G) && k < 80) begin
         ctl_step(); k++;
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL dwell_seek t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      ctl_left = G - 1;
      for (int i = 0; i < 12; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL dwell_short_run t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if ({fault, fault_code} !== 3'b110) begin
         miscompares++;
         $display("FAIL dwell_short got f=%b c=%0d want f=1 c=2", fault, fault_code);
      end
      cur_clr = 1'b1;
      for (int i = 0; i < 20; i++) ctl_step();
      k = 0;
      while (!(ctl_phase == 3 && ctl_left == Y) && k < 80) begin ctl_step(); k++; end
      ctl_left = Y + 1;
      for (int i = 0; i < 10; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL dwell_long_run t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if ({fault, fault_code} !== 3'b111) begin
         miscompares++;
         $display("FAIL dwell_long got f=%b c=%0d want f=1 c=3", fault, fault_code);
      end
   endtask

   task automatic test_skip();
      int k;
      cur_clr = 1'b1;
      for (int i = 0; i < 20; i++) ctl_step();
      k = 0;
      while (!(ctl_phase == 1 && ctl_left == Y) && k < 80) begin ctl_step(); k++; end
      ctl_phase = 2; ctl_left = G;
      for (int i = 0; i < 6; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL skip_run t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if ({fault, fault_code} !== 3'b101) begin
         miscompares++;
         $display("FAIL skip_seq got f=%b c=%0d want f=1 c=1", fault, fault_code);
      end
      inj_pend = 1'b1; inj_pat = rand_illegal();
      ctl_step();
      cur_clr = 1'b1;
      ctl_step();
      vectors++;
      if ({fault, fault_code} !== 3'b100) begin
         miscompares++;
         $display("FAIL clr_vs_illegal got f=%b c=%0d want f=1 c=0", fault, fault_code);
      end
      cur_clr = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL skip_recover t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         if (ctl_left == nominal(ctl_phase)) begin
            if ($urandom_range(0, 59) == 0) begin
               ctl_phase = (ctl_phase + 1) % 8; ctl_left = nominal(ctl_phase);
            end else if ($urandom_range(0, 19) == 0) begin
               ctl_left = ctl_left + ($urandom_range(0, 1) ? 1 : -1);
            end
         end
         if ($urandom_range(0, 149) == 0) begin inj_pend = 1'b1; inj_pat = rand_illegal(); end
         if ($urandom_range(0, 39) == 0) cur_clr = 1'b1;
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL random t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
   endtask

   task automatic test_reset_mid();
      int k;
      cur_clr = 1'b1;
      for (int i = 0; i < 30; i++) ctl_step();
      k = 0;
      while (!(ctl_phase == 5 && ctl_left == 3) && k < 80) begin ctl_step(); k++; end
      vectors++;
      if (k >= 80) begin
         miscompares++;
         $display("FAIL seek_phase5 timeout got %0d steps want <80", k);
      end
      #3 rst = 1'b0;
      #1;
      vectors++;
      if ({locked, phase, fault, fault_code, rotations} !== 15'd0) begin
         miscompares++;
         $display("FAIL async_reset got %h want 0", {locked, phase, fault, fault_code, rotations});
      end
      model_reset();
      #1 rst = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ctl_step();
         vectors++;
         if ({locked, phase, fault, fault_code, rotations} !== exp_out()) begin
            miscompares++;
            $display("FAIL resync t=%0d got %h want %h", tcount, {locked, phase, fault, fault_code, rotations}, exp_out());
         end
      end
      vectors++;
      if ({locked, fault} !== 2'b10) begin
         miscompares++;
         $display("FAIL relock_after_rst got lk=%b f=%b want lk=1 f=0", locked, fault);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_illegal();
      test_dwell();
      test_skip();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
